// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if -- handshake bundle between the pipeline stages and pipe_ctrl.
//
// Requests into the controller:
//   stallreq_if  IF wait request
//   stallreq_id  ID load-use request
//   stallreq_ex  EX single-cycle request
//   mc_start     pulse, EX starts a multi-cycle op
//   mc_len[4:0]  multi-cycle op length in cycles (0 behaves as 1)
//   br_req       pulse, taken branch
//   br_addr      branch target
//   exc_req      pulse, invalid instruction
//   int_req      pulse, timer interrupt
// Controls out of the controller:
//   ctrl_stall   per-stage stall [0] PC [1] IF/ID [2] ID/EX [3] EX/MEM
//                [4] MEM/WB [5] reserved 0
//   redir_en     PC must load redir_addr this cycle
//   redir_addr   redirect target (0 when no redirect)
//   flush        squash IF/ID and ID/EX
//   mc_busy      multi-cycle op in progress
//   mc_done      last cycle of the multi-cycle op
//
// Modports: master = pipeline side, slave = pipe_ctrl.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        mc_start;
  logic [4:0]  mc_len;
  logic        br_req;
  logic [31:0] br_addr;
  logic        exc_req;
  logic        int_req;
  logic [5:0]  ctrl_stall;
  logic        redir_en;
  logic [31:0] redir_addr;
  logic        flush;
  logic        mc_busy;
  logic        mc_done;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, mc_start, mc_len,
           br_req, br_addr, exc_req, int_req,
    input  ctrl_stall, redir_en, redir_addr, flush, mc_busy, mc_done
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, mc_start, mc_len,
           br_req, br_addr, exc_req, int_req,
    output ctrl_stall, redir_en, redir_addr, flush, mc_busy, mc_done
  );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard / redirect controller.
//
// Merges stage stall requests into a per-stage stall vector, sequences
// multi-cycle EX operations (RUN/MCOP), and arbitrates control-flow
// redirects (timer interrupt > invalid instruction > branch). A redirect
// that arrives while the PC is stalled is held in a single pending slot and
// issued in the first cycle the PC is free; flush follows every issued
// redirect by one cycle.
//
// Ports:
//   clk   single clock, all state on the rising edge
//   rst   asynchronous active-low reset; while low all outputs are 0
//   bus   pipe_ctrl_if.slave (see pipe_ctrl_if.sv for the signal list)
//
// Parameters:
//   INT_VEC  timer-interrupt redirect address
//   EXC_VEC  invalid-instruction redirect address
//
// Build option: define TIMER_INT_EN to honour int_req; without it int_req
// is ignored and only exception and branch redirects exist.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter logic [31:0] INT_VEC = 32'h0000_0040,
  parameter logic [31:0] EXC_VEC = 32'h0000_0080
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {RUN, MCOP} state_t;

  // Numeric order is the redirect priority, so "strictly higher" is a plain
  // magnitude compare.
  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_BR   = 2'd1,
    K_EXC  = 2'd2,
    K_INT  = 2'd3
  } kind_t;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_IF = 6'b000011;

  state_t      state, state_nxt;
  logic [4:0]  count, count_nxt;     // MCOP cycles left, including the current one
  logic        pend_valid, pend_valid_nxt;
  kind_t       pend_kind, pend_kind_nxt;
  logic [31:0] pend_addr, pend_addr_nxt;
  logic        flush_q;

  logic        int_hit;
  logic [4:0]  op_len;
  logic        start_acc;
  logic        busy, done;
  logic [5:0]  stall;
  kind_t       new_kind, cand_kind;
  logic [31:0] new_addr, cand_addr;
  logic        issue;

`ifdef TIMER_INT_EN
  assign int_hit = bus.int_req;
`else
  logic int_req_unused;
  assign int_hit        = 1'b0;
  assign int_req_unused = bus.int_req;
`endif

  assign op_len    = (bus.mc_len == 5'd0) ? 5'd1 : bus.mc_len;
  assign start_acc = (state == RUN) && bus.mc_start;

  // Multi-cycle sequencer: the start cycle itself is the first stalled
  // cycle, so only op_len-1 cycles are spent in MCOP.
  // NOTE: every always_comb output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    busy      = 1'b0;
    done      = 1'b0;
    if (state == MCOP) begin
      busy = 1'b1;
      if (count == 5'd1) begin
        done      = 1'b1;
        state_nxt = RUN;
        count_nxt = 5'd0;
      end else begin
        count_nxt = count - 5'd1;
      end
    end else if (bus.mc_start) begin
      busy = 1'b1;
      if (op_len == 5'd1) begin
        done = 1'b1;
      end else begin
        state_nxt = MCOP;
        count_nxt = op_len - 5'd1;
      end
    end
  end

  always_comb begin
    stall = 6'b000000;
    if ((state == MCOP) || start_acc || bus.stallreq_ex) stall = STALL_EX;
    else if (bus.stallreq_id)                             stall = STALL_ID;
    else if (bus.stallreq_if)                             stall = STALL_IF;
  end

  // Highest-priority request arriving this cycle; lower same-cycle pulses
  // are simply not selected.
  always_comb begin
    new_kind = K_NONE;
    new_addr = 32'h0;
    if (int_hit) begin
      new_kind = K_INT;
      new_addr = INT_VEC;
    end else if (bus.exc_req) begin
      new_kind = K_EXC;
      new_addr = EXC_VEC;
    end else if (bus.br_req) begin
      new_kind = K_BR;
      new_addr = bus.br_addr;
    end
  end

  // The pending slot and the new request compete; the new one wins only
  // when strictly higher, so an equal or lower request is dropped.
  always_comb begin
    cand_kind = pend_valid ? pend_kind : K_NONE;
    cand_addr = pend_addr;
    if (new_kind > cand_kind) begin
      cand_kind = new_kind;
      cand_addr = new_addr;
    end
  end

  assign issue = rst && (cand_kind != K_NONE) && !stall[0];

  always_comb begin
    pend_valid_nxt = 1'b0;
    pend_kind_nxt  = K_NONE;
    pend_addr_nxt  = 32'h0;
    if ((cand_kind != K_NONE) && !issue) begin
      pend_valid_nxt = 1'b1;
      pend_kind_nxt  = cand_kind;
      pend_addr_nxt  = cand_addr;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      count      <= 5'd0;
      pend_valid <= 1'b0;
      pend_kind  <= K_NONE;
      pend_addr  <= 32'h0;
      flush_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      pend_valid <= pend_valid_nxt;
      pend_kind  <= pend_kind_nxt;
      pend_addr  <= pend_addr_nxt;
      flush_q    <= issue;
    end
  end

  // NOTE: the combinational outputs also depend on live inputs, so they are
  // gated by rst to stay 0 for the whole time reset is held, not just after
  // the flops clear.
  assign bus.ctrl_stall = stall & {6{rst}};
  assign bus.mc_busy    = busy && rst;
  assign bus.mc_done    = done && rst;
  assign bus.redir_en   = issue;
  assign bus.redir_addr = issue ? cand_addr : 32'h0;
  assign bus.flush      = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
// Directed scenarios with literal expectations, then randomized traffic.
// A behavioural model (remaining-op-cycles count, integer priorities and a
// pending record) predicts every output each cycle; outputs are sampled on
// the falling edge while inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef TIMER_INT_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_op_left = 0, m_op_left_n = 0;  // stalled cycles still owed by an op
  bit          m_pv = 0, m_pv_n = 0;
  int          m_pprio = 0, m_pprio_n = 0;      // 3 int, 2 exc, 1 branch
  logic [31:0] m_paddr = 0, m_paddr_n = 0;
  bit          m_flush = 0, m_flush_n = 0;

  always @(negedge clk) begin
    int          l, nprio, cprio;
    logic [31:0] naddr, caddr;
    bit          busy, done, issue;
    logic [5:0]  es;
    logic [31:0] ea;
    busy = 0; done = 0; issue = 0; es = 6'd0; ea = 32'd0;
    m_op_left_n = 0; m_pv_n = 0; m_pprio_n = 0; m_paddr_n = 0; m_flush_n = 0;
    if (rst) begin
      m_op_left_n = m_op_left;
      l = (bus.mc_len == 5'd0) ? 1 : int'(bus.mc_len);
      if (m_op_left > 0) begin
        busy = 1; done = (m_op_left == 1); m_op_left_n = m_op_left - 1;
      end else if (bus.mc_start) begin
        busy = 1; done = (l == 1); m_op_left_n = l - 1;
      end
      if (busy || bus.stallreq_ex) es = 6'b001111;
      else if (bus.stallreq_id)    es = 6'b000111;
      else if (bus.stallreq_if)    es = 6'b000011;

      nprio = 0; naddr = 32'd0;
      if (INT_ON && bus.int_req) begin nprio = 3; naddr = 32'h0000_0040; end
      else if (bus.exc_req)      begin nprio = 2; naddr = 32'h0000_0080; end
      else if (bus.br_req)       begin nprio = 1; naddr = bus.br_addr;   end
      cprio = m_pv ? m_pprio : 0;
      caddr = m_paddr;
      if (nprio > cprio) begin cprio = nprio; caddr = naddr; end
      issue = (cprio > 0) && !es[0];
      if (issue) ea = caddr;
      m_pv_n    = (cprio > 0) && !issue;
      m_pprio_n = m_pv_n ? cprio : 0;
      m_paddr_n = m_pv_n ? caddr : 32'd0;
      m_flush_n = issue;
    end
    check("model_stall", 32'(bus.ctrl_stall), 32'(es));
    check("model_busy",  32'(bus.mc_busy),    32'(busy));
    check("model_done",  32'(bus.mc_done),    32'(done));
    check("model_redir", 32'(bus.redir_en),   32'(issue));
    check("model_addr",  bus.redir_addr,      ea);
    check("model_flush", 32'(bus.flush),      32'(rst ? m_flush : 1'b0));
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_op_left <= 0; m_pv <= 0; m_pprio <= 0; m_paddr <= 0; m_flush <= 0;
    end else begin
      m_op_left <= m_op_left_n; m_pv <= m_pv_n; m_pprio <= m_pprio_n;
      m_paddr <= m_paddr_n; m_flush <= m_flush_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.stallreq_if = 0; bus.stallreq_id = 0; bus.stallreq_ex = 0;
    bus.mc_start = 0; bus.mc_len = 0; bus.br_req = 0; bus.br_addr = 0;
    bus.exc_req = 0; bus.int_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] st, input bit en,
                         input logic [31:0] ad, input bit fl, input bit bz, input bit dn);
    check({tag, "_stall"}, 32'(bus.ctrl_stall), 32'(st));
    check({tag, "_redir"}, 32'(bus.redir_en),   32'(en));
    check({tag, "_addr"},  bus.redir_addr,      ad);
    check({tag, "_flush"}, 32'(bus.flush),      32'(fl));
    check({tag, "_busy"},  32'(bus.mc_busy),    32'(bz));
    check({tag, "_done"},  32'(bus.mc_done),    32'(dn));
  endtask

  initial begin
    // Reset with active requests on the inputs: everything must read 0.
    rst = 0; idle();
    bus.stallreq_ex = 1; bus.mc_start = 1; bus.mc_len = 5'd3;
    bus.br_req = 1; bus.br_addr = 32'h0000_1234;
    @(negedge clk); chk_out("reset", 6'h00, 0, 32'h0, 0, 0, 0);
    step(); rst = 1; idle();

    // Multi-cycle op, length 4.
    step(); bus.mc_start = 1; bus.mc_len = 5'd4;
    @(negedge clk); chk_out("mc4_c1", 6'b001111, 0, 32'h0, 0, 1, 0);
    step(); idle();
    @(negedge clk); chk_out("mc4_c2", 6'b001111, 0, 32'h0, 0, 1, 0);
    step();
    @(negedge clk); chk_out("mc4_c3", 6'b001111, 0, 32'h0, 0, 1, 0);
    step();
    @(negedge clk); chk_out("mc4_c4", 6'b001111, 0, 32'h0, 0, 1, 1);
    step();
    @(negedge clk); chk_out("mc4_after", 6'h00, 0, 32'h0, 0, 0, 0);

    // Length 0 behaves as a single-cycle op.
    step(); bus.mc_start = 1; bus.mc_len = 5'd0;
    @(negedge clk); chk_out("mc0", 6'b001111, 0, 32'h0, 0, 1, 1);
    step(); idle();
    @(negedge clk); chk_out("mc0_after", 6'h00, 0, 32'h0, 0, 0, 0);

    // Unstalled branch.
    step(); bus.br_req = 1; bus.br_addr = 32'h0000_1234;
    @(negedge clk); chk_out("br", 6'h00, 1, 32'h0000_1234, 0, 0, 0);
    step(); idle();
    @(negedge clk); chk_out("br_flush", 6'h00, 0, 32'h0, 1, 0, 0);
    step();
    @(negedge clk); chk_out("br_flush_end", 6'h00, 0, 32'h0, 0, 0, 0);

    // Branch during a 3-cycle load-use stall.
    step(); bus.stallreq_id = 1; bus.br_req = 1; bus.br_addr = 32'h0000_1234;
    @(negedge clk); chk_out("brid_c1", 6'b000111, 0, 32'h0, 0, 0, 0);
    step(); bus.br_req = 0; bus.br_addr = 0;
    @(negedge clk); chk_out("brid_c2", 6'b000111, 0, 32'h0, 0, 0, 0);
    step();
    @(negedge clk); chk_out("brid_c3", 6'b000111, 0, 32'h0, 0, 0, 0);
    step(); bus.stallreq_id = 0;
    @(negedge clk); chk_out("brid_issue", 6'h00, 1, 32'h0000_1234, 0, 0, 0);
    step();
    @(negedge clk); chk_out("brid_flush", 6'h00, 0, 32'h0, 1, 0, 0);

    // IF-only stall vector.
    step(); bus.stallreq_if = 1;
    @(negedge clk); chk_out("if_stall", 6'b000011, 0, 32'h0, 0, 0, 0);
    step(); idle();

    // Interrupt and branch in the same cycle.
    step(); bus.int_req = 1; bus.br_req = 1; bus.br_addr = 32'h0000_1234;
    @(negedge clk);
    chk_out("int_br", 6'h00, 1, INT_ON ? 32'h0000_0040 : 32'h0000_1234, 0, 0, 0);
    step(); idle();
    @(negedge clk); chk_out("int_br_next", 6'h00, 0, 32'h0, 1, 0, 0);

    // Exception in the 2nd cycle of a length-6 op.
    step(); bus.mc_start = 1; bus.mc_len = 5'd6;
    @(negedge clk); chk_out("exc_c1", 6'b001111, 0, 32'h0, 0, 1, 0);
    step(); idle(); bus.exc_req = 1;
    @(negedge clk); chk_out("exc_c2", 6'b001111, 0, 32'h0, 0, 1, 0);
    step(); idle();
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk); chk_out("exc_mid", 6'b001111, 0, 32'h0, 0, 1, 0);
      step();
    end
    @(negedge clk); chk_out("exc_c6", 6'b001111, 0, 32'h0, 0, 1, 1);
    step();
    @(negedge clk); chk_out("exc_issue", 6'h00, 1, 32'h0000_0080, 0, 0, 0);
    step();
    @(negedge clk); chk_out("exc_flush", 6'h00, 0, 32'h0, 1, 0, 0);

    // Reset in the 3rd cycle of a length-8 op with a branch pending.
    step(); bus.mc_start = 1; bus.mc_len = 5'd8;
    @(negedge clk);
    step(); idle(); bus.br_req = 1; bus.br_addr = 32'h0000_1234;
    @(negedge clk); chk_out("rst8_c2", 6'b001111, 0, 32'h0, 0, 1, 0);
    step(); idle(); rst = 0;
    #1 chk_out("rst8_now", 6'h00, 0, 32'h0, 0, 0, 0);
    step(); rst = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("rst8_no_done",  32'(bus.mc_done),  32'd0);
      check("rst8_no_redir", 32'(bus.redir_en), 32'd0);
    end

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      step();
      bus.stallreq_if = ($urandom_range(0, 9) == 0);
      bus.stallreq_id = ($urandom_range(0, 9) == 0);
      bus.stallreq_ex = ($urandom_range(0, 11) == 0);
      bus.mc_start    = ($urandom_range(0, 12) == 0);
      bus.mc_len      = ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.br_req      = ($urandom_range(0, 5) == 0);
      bus.br_addr     = $urandom;
      bus.exc_req     = ($urandom_range(0, 19) == 0);
      bus.int_req     = ($urandom_range(0, 19) == 0);
      rst             = ($urandom_range(0, 299) != 0);
    end
    step(); idle(); rst = 1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter INT_VEC, default 32'h0000_0040, timer-interrupt redirect address.
REQ-002 SHALL provide parameter EXC_VEC, default 32'h0000_0080, invalid-instruction redirect address.
REQ-003 SHALL have ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- stallreq_if  input  1  IF wait request.
- stallreq_id  input  1  ID load-use request.
- stallreq_ex  input  1  EX single-cycle request.
- mc_start  input  1  pulse; EX starts a multi-cycle op.
- mc_len  input  5  multi-cycle op length in cycles.
- br_req  input  1  pulse; taken branch.
- br_addr  input  32  branch target.
- exc_req  input  1  pulse; invalid instruction.
- int_req  input  1  pulse; timer interrupt.
- ctrl_stall  output  6  per-stage stall: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved 0.
- redir_en  output  1  PC must load redir_addr.
- redir_addr  output  32  redirect target.
- flush  output  1  squash IF/ID and ID/EX.
- mc_busy  output  1  multi-cycle op in progress.
- mc_done  output  1  last cycle of multi-cycle op.

Function
REQ-004 SHALL use states RUN and MCOP, plus a pending-redirect register (valid, kind, addr).
REQ-005 SHALL drive ctrl_stall combinationally, highest rule first: MCOP, mc_start accepted, or stallreq_ex -> 6'b001111; stallreq_id -> 6'b000111; stallreq_if -> 6'b000011; else 6'b000000.
REQ-006 SHALL accept mc_start only in RUN; mc_len 0 treated as 1; a start in MCOP is ignored.
REQ-007 SHALL stall EX for exactly L cycles: the start cycle plus L-1 MCOP cycles. Return RUN after the last; mc_busy high for all L cycles.
REQ-008 SHALL pulse mc_done for one cycle in the last stalled cycle; with L=1 in the start cycle, staying in RUN.
REQ-009 SHALL rank redirect sources int_req > exc_req > br_req. Same-cycle pulses select the highest; lower ones are dropped.
REQ-010 SHALL assert redir_en in the pulse cycle when ctrl_stall[0]=0 and no redirect is pending. redir_addr is INT_VEC, EXC_VEC or br_addr.
REQ-011 SHALL, when ctrl_stall[0]=1 in the pulse cycle, latch the request as pending. redir_en/redir_addr are driven from it in the first cycle ctrl_stall[0]=0, then it clears.
REQ-012 SHALL let a new request replace a pending one only when strictly higher priority; otherwise the new request is dropped.
REQ-013 SHALL register flush high for exactly one cycle after any cycle with redir_en=1 and ctrl_stall[0]=0.
REQ-014 SHALL NOT abort MCOP on interrupt or exception; the request stays pending until the op completes.
REQ-015 SHALL hold redir_en=0 and redir_addr=0 when no redirect is issued.

Reset
REQ-016 SHALL, while rst=0: set state RUN, count 0, pending valid 0, flush 0; force ctrl_stall=0, redir_en=0, mc_busy=0, mc_done=0.
REQ-017 SHALL, on rst asserted mid-MCOP or with a redirect pending, discard both with no later redir_en or mc_done.
REQ-018 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-019 SHALL, with TIMER_INT_EN defined, honour int_req per REQ-009..012.
REQ-020 SHALL, without TIMER_INT_EN, ignore int_req entirely: INT_VEC never issued, kinds limited to exception and branch.

Verification
REQ-021 SHALL cover: mc_start with mc_len=4 in RUN -> ctrl_stall=6'b001111 four cycles, mc_busy four cycles, mc_done on 4th, then 6'b000000.
REQ-022 SHALL cover: br_req with br_addr=32'h0000_1234, no stall -> same-cycle redir_en=1, redir_addr=32'h0000_1234, flush=1 next cycle only.
REQ-023 SHALL cover: br_req during stallreq_id held 3 cycles -> no redir_en for 3 cycles, then one redir_en with 32'h0000_1234, flush one cycle later.
REQ-024 SHALL cover: int_req and br_req same cycle, TIMER_INT_EN defined -> redir_addr=32'h0000_0040, branch dropped; undefined -> redir_addr=br_addr.
REQ-025 SHALL cover: exc_req during MCOP (mc_len=6, 2nd cycle) -> redir_en=1 with 32'h0000_0080 in first cycle after mc_done.
REQ-026 SHALL cover: rst low in 3rd cycle of mc_len=8 with a branch pending -> all outputs 0 immediately; after release no mc_done, no redir_en.
